// File: rtl/axis_st_sync_fifo.sv
// axis_st_sync_fifo: synchronous AXI4-Stream FIFO with a show-ahead output.
//
// Beats (tdata/tkeep/tlast) are buffered between the s_* slave port and the
// m_* master port. Both s_tready and m_tvalid are registered, so nothing
// combinational runs from m_tready to s_tready. The head of the FIFO is
// always presented on m_tdata/m_tkeep/m_tlast, and level reports the number
// of stored beats.
//
// Optional build macro AXIS_ST_FIFO_PKT_MODE_EN selects store-and-forward
// operation. In that mode a beat is only offered downstream when a complete
// packet is stored, or when the FIFO is full (so oversize packets cannot
// deadlock). Without the macro the FIFO is pure cut-through.
module axis_st_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_tkeep,
    input  logic                         s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [KEEP_WIDTH-1:0]        m_tkeep,
    output logic                         m_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Storage: {tlast, tkeep, tdata} per entry, never cleared by reset.
    logic [BEAT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              s_tready_q, s_tready_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              push, pop;
    logic              release_ok;
    logic [BEAT_W-1:0] head;

    assign push = s_tvalid && s_tready_q;
    assign pop  = m_tvalid_q && m_tready;

    // Pointer advance with explicit wrap, and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

`ifdef AXIS_ST_FIFO_PKT_MODE_EN
    logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             push_last, pop_last;

    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    // Count complete packets held in storage.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({push_last, pop_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Packet counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Without a pop neither level nor pkt_cnt can fall, so once released a
    // beat stays valid until it leaves; no separate hold term is needed.
    assign release_ok = (pkt_cnt_d != '0) || (level_d == LVL_FULL);
`else
    assign release_ok = 1'b1;
`endif

    // Registered handshake flags derived from the next occupancy.
    always_comb begin
        s_tready_d = (level_d != LVL_FULL);
        m_tvalid_d = (level_d != '0) && release_ok;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    // Beat storage write; push is impossible while in reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tkeep, s_tdata};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign m_tdata  = head[DATA_WIDTH-1:0];
    assign m_tkeep  = head[DATA_WIDTH +: KEEP_WIDTH];
    assign m_tlast  = head[BEAT_W-1];
    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign level    = level_q;

endmodule
